// File: rtl/rv_pkg.sv
// Shared fetch-stage types and constants for the RV32I core.
package rv_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HALT = 2'd3
    } fetch_state_e;

    localparam int unsigned INSTR_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    function automatic logic word_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_ctrl_pc_target_calc.sv
// Redirect target generation: B-type branch offset add, JALR bit-0 clear, JALR-over-branch priority.
module pc_target_calc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IMM_W = 13
) (
    input  logic             br_taken_i,
    input  logic [WIDTH-1:0] br_pc_i,
    input  logic [IMM_W-1:0] imm_i,
    input  logic             jalr_i,
    input  logic [WIDTH-1:0] jalr_target_i,
    output logic             redirect_o,
    output logic [WIDTH-1:0] target_o
);

    localparam logic [WIDTH-1:0] JALR_MASK = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [WIDTH-1:0] imm_sext_s;
    logic [WIDTH-1:0] br_target_s;
    logic [WIDTH-1:0] jalr_masked_s;

    // Target arithmetic and source selection
    always_comb begin
        imm_sext_s    = {{(WIDTH-IMM_W){imm_i[IMM_W-1]}}, imm_i};
        br_target_s   = br_pc_i + imm_sext_s;
        jalr_masked_s = jalr_target_i & JALR_MASK;
        redirect_o    = br_taken_i | jalr_i;
        if (jalr_i) begin
            target_o = jalr_masked_s;
        end else begin
            target_o = br_target_s;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// PC sequencing and single-outstanding imem fetch with a one-entry decode buffer.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect traps and halts fetch instead of aligning.
module fetch_ctrl
    import rv_pkg::*;
#(
    parameter int unsigned       WIDTH    = 32,
    parameter int unsigned       IMM_W    = 13,
    parameter logic [WIDTH-1:0]  RESET_PC = {WIDTH{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               br_taken_i,
    input  logic [WIDTH-1:0]   br_pc_i,
    input  logic [IMM_W-1:0]   imm_i,
    input  logic               jalr_i,
    input  logic [WIDTH-1:0]   jalr_target_i,
    output logic               imem_req_o,
    output logic [WIDTH-1:0]   imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [WIDTH-1:0]   instr_pc_o,
    output logic               flush_o,
    output logic               misalign_o
);

    fetch_state_e       state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [WIDTH-1:0]   iss_pc_q, iss_pc_d;
    logic               drop_q, drop_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [WIDTH-1:0]   instr_pc_q, instr_pc_d;
    logic               misalign_q, misalign_d;

    logic               redirect_s;
    logic               redir_s;
    logic               trap_s;
    logic               req_s;
    logic               hs_s;
    logic [WIDTH-1:0]   target_s;
    logic [WIDTH-1:0]   tgt_aligned_s;

    pc_target_calc #(
        .WIDTH (WIDTH),
        .IMM_W (IMM_W)
    ) u_target (
        .br_taken_i    (br_taken_i),
        .br_pc_i       (br_pc_i),
        .imm_i         (imm_i),
        .jalr_i        (jalr_i),
        .jalr_target_i (jalr_target_i),
        .redirect_o    (redirect_s),
        .target_o      (target_s)
    );

    // Once halted, redirects are no longer honoured.
    assign redir_s = redirect_s & (state_q != S_HALT);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign trap_s        = redir_s & word_misaligned(target_s[1:0]);
    assign tgt_aligned_s = target_s;
`else
    assign trap_s        = 1'b0;
    assign tgt_aligned_s = target_s & {{(WIDTH-2){1'b1}}, 2'b00};
`endif

    // Next-state, fetch handshake, buffer update and redirect overlay
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        iss_pc_d   = iss_pc_q;
        drop_d     = drop_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        misalign_d = trap_s;
        req_s      = 1'b0;
        hs_s       = 1'b0;
        if (valid_q && !stall_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            S_BOOT: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                req_s = !valid_q || !stall_i;
                hs_s  = req_s && imem_gnt_i;
                if (hs_s) begin
                    iss_pc_d = pc_q;
                    pc_d     = pc_q + WIDTH'(PC_STEP);
                    state_d  = S_WAIT;
                    if (redir_s) begin
                        drop_d = 1'b1;
                    end else begin
                        drop_d = drop_q;
                    end
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = S_REQ;
                    drop_d  = 1'b0;
                    if (!drop_q && !redir_s) begin
                        instr_d    = imem_rdata_i;
                        instr_pc_d = iss_pc_q;
                        valid_d    = 1'b1;
                    end else begin
                        instr_d    = instr_q;
                        instr_pc_d = instr_pc_q;
                    end
                end else begin
                    state_d = S_WAIT;
                    if (redir_s) begin
                        drop_d = 1'b1;
                    end else begin
                        drop_d = drop_q;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        // A redirect overrides stall and any sequential PC advance.
        if (trap_s) begin
            state_d = S_HALT;
            pc_d    = pc_q;
            valid_d = 1'b0;
            drop_d  = 1'b0;
        end else if (redir_s) begin
            pc_d    = tgt_aligned_s;
            valid_d = 1'b0;
        end else begin
            misalign_d = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            iss_pc_q   <= {WIDTH{1'b0}};
            drop_q     <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= {INSTR_W{1'b0}};
            instr_pc_q <= {WIDTH{1'b0}};
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            iss_pc_q   <= iss_pc_d;
            drop_q     <= drop_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req_o    = req_s;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign flush_o       = redir_s;
    assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios then randomized traffic against a reference model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i, br_taken_i, jalr_i, imem_gnt_i, imem_rvalid_i;
    logic [31:0] br_pc_i, jalr_target_i, imem_rdata_i;
    logic [12:0] imm_i;
    logic        imem_req_o, instr_valid_o, flush_o, misalign_o;
    logic [31:0] imem_addr_o, instr_o, instr_pc_o;

    int checks   = 0;
    int failures = 0;

    fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .br_taken_i    (br_taken_i),
        .br_pc_i       (br_pc_i),
        .imm_i         (imm_i),
        .jalr_i        (jalr_i),
        .jalr_target_i (jalr_target_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .flush_o       (flush_o),
        .misalign_o    (misalign_o)
    );

    always #5 clk = ~clk;

    // Reference model: fetch progress as flags and the architectural buffer contents.
    bit          m_boot, m_wait, m_halt, m_drop, m_valid, m_mis;
    logic [31:0] m_pc, m_iss, m_instr, m_ipc;
    // Memory responder
    bit          r_pend;
    int          r_cnt;
    logic [31:0] r_addr;
    int          gnt_pct = 100, lat_lo = 1, lat_hi = 1, junk_pct = 0;
    logic [31:0] hs_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_0013 + (a << 5);
    endfunction

    function automatic logic [31:0] redirect_target();
        int off;
        off = $signed(imm_i);
        if (jalr_i) return jalr_target_i & 32'hFFFF_FFFE;
        return br_pc_i + off;
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic        exp_req, red, hs, trap;
        logic [31:0] tgt;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
        if (r_pend) begin
            if (r_cnt == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_word(r_addr);
                r_pend        = 1'b0;
            end else begin
                r_cnt--;
            end
        end else if ($urandom_range(99) < junk_pct) begin
            imem_rvalid_i = 1'b1;
        end
        imem_gnt_i = ($urandom_range(99) < gnt_pct);
        @(negedge clk);
        exp_req = !m_boot && !m_wait && !m_halt && (!m_valid || !stall_i);
        red     = (br_taken_i || jalr_i) && !m_halt;
        tgt     = redirect_target();
        chk1("req", imem_req_o, exp_req);
        chk32("addr", imem_addr_o, m_pc);
        chk1("valid", instr_valid_o, m_valid);
        chk32("instr", instr_o, m_instr);
        chk32("instr_pc", instr_pc_o, m_ipc);
        chk1("flush", flush_o, red);
        chk1("misalign", misalign_o, m_mis);
        hs   = exp_req && imem_gnt_i;
        trap = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        trap = red && (tgt[1:0] != 2'b00);
`else
        tgt[1:0] = 2'b00;
`endif
        if (hs) begin
            hs_q.push_back(m_pc);
            r_pend = 1'b1;
            r_cnt  = $urandom_range(lat_hi - 1, lat_lo - 1);
            r_addr = m_pc;
        end
        if (m_valid && !stall_i) m_valid = 1'b0;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (hs) begin
            m_wait = 1'b1;
            m_iss  = m_pc;
            m_pc   = m_pc + 32'd4;
            if (red) m_drop = 1'b1;
        end else if (m_wait && imem_rvalid_i) begin
            m_wait = 1'b0;
            if (!m_drop && !red) begin
                m_instr = imem_rdata_i;
                m_ipc   = m_iss;
                m_valid = 1'b1;
            end
            m_drop = 1'b0;
        end else if (m_wait && red) begin
            m_drop = 1'b1;
        end
        m_mis = trap;
        if (trap) begin
            m_halt  = 1'b1;
            m_wait  = 1'b0;
            m_valid = 1'b0;
        end else if (red) begin
            m_pc    = tgt;
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall_i = 1'b0; br_taken_i = 1'b0; jalr_i = 1'b0;
        br_pc_i = 32'd0; imm_i = 13'd0; jalr_target_i = 32'd0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        #1;
        chk1("rst_req", imem_req_o, 1'b0);
        chk32("rst_addr", imem_addr_o, 32'd0);
        chk1("rst_valid", instr_valid_o, 1'b0);
        chk32("rst_instr", instr_o, 32'd0);
        chk32("rst_ipc", instr_pc_o, 32'd0);
        chk1("rst_mis", misalign_o, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_boot = 1'b1; m_wait = 1'b0; m_halt = 1'b0; m_drop = 1'b0; m_valid = 1'b0; m_mis = 1'b0;
        m_pc = 32'd0; m_iss = 32'd0; m_instr = 32'd0; m_ipc = 32'd0;
        r_pend = 1'b0;
        hs_q.delete();
    endtask

    // Run until the next request handshake; optionally require an empty buffer meanwhile.
    task automatic next_hs(input string tag, input bit want_idle, input logic [31:0] exp_addr);
        int n0;
        int n;
        n0 = hs_q.size();
        n  = 0;
        while (hs_q.size() == n0 && n < 40) begin
            if (want_idle) chk1({tag, "_idle"}, instr_valid_o, 1'b0);
            cycle();
            n++;
        end
        chk1({tag, "_timeout"}, (n < 40), 1'b1);
        if (hs_q.size() > n0) chk32({tag, "_addr"}, hs_q[n0], exp_addr);
    endtask

    task automatic wait_req_state(input string tag);
        int n;
        n = 0;
        while ((m_wait || m_boot) && n < 40) begin
            cycle();
            n++;
        end
        chk1({tag, "_reqwait"}, (n < 40), 1'b1);
    endtask

    initial begin
        int          first_valid;
        int          n;
        logic [31:0] ipcs[$];
        logic [31:0] words[$];
        logic [31:0] held_instr, held_pc;

        #2;
        // 1: basic streaming with a 1-cycle memory
        do_reset();
        first_valid = -1;
        for (int i = 0; i < 10; i++) begin
            if (instr_valid_o === 1'b1) begin
                if (first_valid < 0) first_valid = i;
                ipcs.push_back(instr_pc_o);
                words.push_back(instr_o);
            end
            cycle();
        end
        chk32("t1_first_valid", first_valid, 32'd3);
        chk32("t1_hs0", hs_q[0], 32'h0);
        chk32("t1_hs1", hs_q[1], 32'h4);
        chk32("t1_hs2", hs_q[2], 32'h8);
        chk32("t1_ipc0", ipcs[0], 32'h0);
        chk32("t1_ipc1", ipcs[1], 32'h4);
        chk32("t1_ipc2", ipcs[2], 32'h8);
        chk32("t1_word0", words[0], 32'h13);
        chk32("t1_word1", words[1], 32'h93);

        // 2: stall with a full buffer
        stall_i = 1'b1;
        n = 0;
        while (instr_valid_o !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        chk1("t2_fill", instr_valid_o, 1'b1);
        held_instr = instr_o;
        held_pc    = instr_pc_o;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk1("t2_req", imem_req_o, 1'b0);
            chk32("t2_instr", instr_o, held_instr);
            chk32("t2_ipc", instr_pc_o, held_pc);
        end
        stall_i = 1'b0;
        next_hs("t2_resume", 1'b0, held_pc + 32'd4);

        // 3: branch while a fetch is outstanding
        lat_lo = 3; lat_hi = 3;
        n = 0;
        while (!(m_wait && r_pend && r_cnt > 0) && n < 40) begin
            cycle();
            n++;
        end
        chk1("t3_inwait", (n < 40), 1'b1);
        br_taken_i = 1'b1; br_pc_i = 32'h10; imm_i = 13'h1FF8;
        #1;
        chk1("t3_flush", flush_o, 1'b1);
        cycle();
        br_taken_i = 1'b0;
        lat_lo = 1; lat_hi = 1;
        next_hs("t3", 1'b1, 32'h8);

        // 4: branch and JALR together, coinciding with a grant
        wait_req_state("t4");
        br_taken_i = 1'b1; br_pc_i = 32'h40; imm_i = 13'h0004;
        jalr_i = 1'b1; jalr_target_i = 32'h101;
        cycle();
        br_taken_i = 1'b0; jalr_i = 1'b0;
        next_hs("t4", 1'b1, 32'h100);

        // 5: PC wrap both by sequential advance and by branch arithmetic
        wait_req_state("t5a");
        gnt_pct = 0;
        jalr_i = 1'b1; jalr_target_i = 32'hFFFF_FFFC;
        cycle();
        jalr_i = 1'b0;
        gnt_pct = 100;
        next_hs("t5_top", 1'b0, 32'hFFFF_FFFC);
        next_hs("t5_wrap", 1'b0, 32'h0);
        wait_req_state("t5b");
        gnt_pct = 0;
        br_taken_i = 1'b1; br_pc_i = 32'h4; imm_i = 13'h1FF8;
        cycle();
        br_taken_i = 1'b0;
        gnt_pct = 100;
        next_hs("t5_neg", 1'b0, 32'hFFFF_FFFC);

        // 6: misaligned branch target
        wait_req_state("t6");
        gnt_pct = 0;
        br_taken_i = 1'b1; br_pc_i = 32'h20; imm_i = 13'h0002;
        #1;
        chk1("t6_flush", flush_o, 1'b1);
        cycle();
        br_taken_i = 1'b0;
        gnt_pct = 100;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk1("t6_mis", misalign_o, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk1("t6_halt_req", imem_req_o, 1'b0);
            chk1("t6_mis_low", misalign_o, 1'b0);
        end
`else
        chk1("t6_mis", misalign_o, 1'b0);
        next_hs("t6", 1'b0, 32'h20);
`endif

        // Randomized traffic, occasional resets (also the only way out of a halt)
        do_reset();
        gnt_pct = 60; lat_lo = 1; lat_hi = 3; junk_pct = 10;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(399) == 0 || (m_halt && $urandom_range(19) == 0)) begin
                do_reset();
            end
            stall_i       = ($urandom_range(99) < 30);
            br_taken_i    = ($urandom_range(99) < 8);
            jalr_i        = ($urandom_range(99) < 4);
            br_pc_i       = ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
            imm_i         = 13'($urandom);
            jalr_target_i = ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
            if ($urandom_range(99) >= 3) begin
                br_pc_i[1:0]       = 2'b00;
                imm_i[1:0]         = 2'b00;
                jalr_target_i[1:0] = 2'b00;
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
